// File: rtl/hex_round_monitor.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : hex_round_monitor
// Description : Passive baccarat observer. Decodes the six card displays and
//               LEDR, recomputes both scores and the winner, and keeps tallies.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module hex_round_monitor #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             CLOCK_50,
   input  logic             resetb,
   input  logic [6:0]       HEX0,
   input  logic [6:0]       HEX1,
   input  logic [6:0]       HEX2,
   input  logic [6:0]       HEX3,
   input  logic [6:0]       HEX4,
   input  logic [6:0]       HEX5,
   input  logic [9:0]       LEDR,
   output logic [3:0]       player_score,
   output logic [3:0]       dealer_score,
   output logic             check_valid,
   output logic             score_ok,
   output logic             error,
   output logic [2:0]       err_code,
   output logic [CNT_W-1:0] rounds,
   output logic [CNT_W-1:0] pwins,
   output logic [CNT_W-1:0] dwins,
   output logic [CNT_W-1:0] ties
);

   localparam int          c_STAB_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [6:0]  c_BLANK  = 7'b1111111;
   localparam logic [51:0] c_IDLE_PINS = {10'd0, {6{c_BLANK}}};

   typedef enum logic [1:0] {
      S_WAIT_BLANK = 2'd0,
      S_IDLE       = 2'd1,
      S_IN_ROUND   = 2'd2,
      S_DONE       = 2'd3
   } state_t;

   // {valid, value}; blank decodes to a valid 0
   function automatic logic [4:0] decode(input logic [6:0] seg);
      case (seg)
         7'b1111111: decode = {1'b1, 4'd0};
         7'b0001000: decode = {1'b1, 4'd1};
         7'b0100100: decode = {1'b1, 4'd2};
         7'b0110000: decode = {1'b1, 4'd3};
         7'b0011001: decode = {1'b1, 4'd4};
         7'b0010010: decode = {1'b1, 4'd5};
         7'b0000010: decode = {1'b1, 4'd6};
         7'b1111000: decode = {1'b1, 4'd7};
         7'b0000000: decode = {1'b1, 4'd8};
         7'b0010000: decode = {1'b1, 4'd9};
         7'b1000000: decode = {1'b1, 4'd10};
         7'b1100001: decode = {1'b1, 4'd11};
         7'b0011000: decode = {1'b1, 4'd12};
         7'b0001001: decode = {1'b1, 4'd13};
         default:    decode = {1'b0, 4'd0};
      endcase
   endfunction

   function automatic logic [3:0] mod10(input logic [4:0] s);
      logic [4:0] r;
      if (s >= 5'd20)      r = s - 5'd20;
      else if (s >= 5'd10) r = s - 5'd10;
      else                 r = s;
      mod10 = r[3:0];
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      sat_inc = (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [51:0]         w_pins;
   logic [51:0]         r_sync1, r_sync2, r_snap, r_prev;
   logic [c_STAB_W-1:0] r_stab;
   logic                r_primed, r_cap;
   state_t              r_state;

   logic [6:0] w_seg  [6];
   logic [3:0] w_pts  [6];
   logic [5:0] w_ok, w_nb, w_changed;

   assign w_pins = {LEDR, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

   for (genvar i = 0; i < 6; i++) begin : g_dec
      logic [4:0] w_d;
      logic [6:0] w_prev_seg;
      assign w_seg[i]     = r_snap[7*i +: 7];
      assign w_prev_seg   = r_prev[7*i +: 7];
      assign w_d          = decode(w_seg[i]);
      assign w_ok[i]      = w_d[4];
      assign w_nb[i]      = (w_seg[i] != c_BLANK);
      assign w_pts[i]     = (w_d[3:0] >= 4'd10) ? 4'd0 : w_d[3:0];
      assign w_changed[i] = (w_prev_seg != c_BLANK) && (w_prev_seg != w_seg[i]);
   end

   logic [9:0] w_led;
   logic [1:0] w_win, w_exp_win;
   logic [3:0] w_pscore, w_dscore;
   logic       w_inv, w_all_blank, w_game_reset, w_order_err, w_score_ok;
   logic       w_check_round, w_done_round, w_same, w_capture;
   logic [2:0] w_code;

   assign w_led        = r_snap[51:42];
   assign w_win        = w_led[9:8];
   assign w_pscore     = mod10(5'(w_pts[0]) + 5'(w_pts[1]) + 5'(w_pts[2]));
   assign w_dscore     = mod10(5'(w_pts[3]) + 5'(w_pts[4]) + 5'(w_pts[5]));
   assign w_inv        = ~&w_ok;
   assign w_all_blank  = ~|w_nb;
   assign w_game_reset = w_all_blank && (w_win == 2'b00);
   assign w_score_ok   = (w_pscore == w_led[3:0]) && (w_dscore == w_led[7:4]);
   assign w_exp_win    = (w_pscore > w_dscore) ? 2'b01 :
                         (w_dscore > w_pscore) ? 2'b10 : 2'b11;
   assign w_order_err  = (w_nb[1] && !(w_nb[0] && w_nb[3])) ||
                         (w_nb[4] && !w_nb[1]) ||
                         (w_nb[2] && !w_nb[4]) ||
                         (w_nb[5] && !w_nb[4]);
   // The snapshot that leaves IDLE is already the first in-round snapshot
   assign w_check_round = (r_state == S_IN_ROUND) ||
                          ((r_state == S_IDLE) && !w_all_blank);
   assign w_done_round  = w_check_round && (w_win != 2'b00);

   always_comb begin
      w_code = 3'd0;
      if (w_inv)                                   w_code = 3'd1;
      else if (w_check_round && w_order_err)       w_code = 3'd3;
      else if (w_check_round && |w_changed)        w_code = 3'd4;
      else if (w_check_round && !w_score_ok)       w_code = 3'd2;
      else if (w_done_round && w_win != w_exp_win) w_code = 3'd5;
   end

   assign w_same    = (r_sync1 == r_sync2);
   assign w_capture = w_same && (r_stab == c_STAB_W'(STABLE_CYCLES - 1)) &&
                      ((r_sync2 != r_snap) || !r_primed);

   always_ff @(posedge CLOCK_50 or negedge resetb) begin
      if (!resetb) begin
         r_sync1      <= c_IDLE_PINS;
         r_sync2      <= c_IDLE_PINS;
         r_snap       <= c_IDLE_PINS;
         r_prev       <= c_IDLE_PINS;
         r_stab       <= '0;
         r_primed     <= 1'b0;
         r_cap        <= 1'b0;
         r_state      <= S_WAIT_BLANK;
         player_score <= '0;
         dealer_score <= '0;
         check_valid  <= 1'b0;
         score_ok     <= 1'b0;
         error        <= 1'b0;
         err_code     <= '0;
         rounds       <= '0;
         pwins        <= '0;
         dwins        <= '0;
         ties         <= '0;
      end else begin
         r_sync1 <= w_pins;
         r_sync2 <= r_sync1;
         if (!w_same)
            r_stab <= '0;
         else if (r_stab != c_STAB_W'(STABLE_CYCLES))
            r_stab <= r_stab + c_STAB_W'(1);

         r_cap       <= w_capture;
         check_valid <= r_cap;
         if (w_capture) begin
            r_snap   <= r_sync2;
            r_primed <= 1'b1;
         end

         if (r_cap) begin
            r_prev       <= r_snap;
            player_score <= w_pscore;
            dealer_score <= w_dscore;
            score_ok     <= w_score_ok;
            if (w_code != 3'd0 && !error) begin
               error    <= 1'b1;
               err_code <= w_code;
            end
            case (r_state)
               S_WAIT_BLANK: if (w_game_reset) r_state <= S_IDLE;
               S_DONE:       if (w_game_reset) r_state <= S_IDLE;
               default:      if (w_check_round) r_state <= w_done_round ? S_DONE : S_IN_ROUND;
            endcase
            if (w_done_round) begin
               rounds <= sat_inc(rounds);
               case (w_exp_win)
                  2'b01:   pwins <= sat_inc(pwins);
                  2'b10:   dwins <= sat_inc(dwins);
                  default: ties  <= sat_inc(ties);
               endcase
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hex_round_monitor.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_hex_round_monitor
// Description : Directed self-checking bench for hex_round_monitor.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_hex_round_monitor;

   localparam logic [6:0] S_BL  = 7'b1111111;
   localparam logic [6:0] S_2   = 7'b0100100;
   localparam logic [6:0] S_3   = 7'b0110000;
   localparam logic [6:0] S_5   = 7'b0010010;
   localparam logic [6:0] S_7   = 7'b1111000;
   localparam logic [6:0] S_9   = 7'b0010000;
   localparam logic [6:0] S_K   = 7'b0001001;
   localparam logic [6:0] S_BAD = 7'b1010101;

   logic       clk = 1'b0;
   logic       resetb = 1'b0;
   logic [6:0] hex0 = S_BL, hex1 = S_BL, hex2 = S_BL, hex3 = S_BL, hex4 = S_BL, hex5 = S_BL;
   logic [9:0] ledr = '0;
   logic [3:0] player_score, dealer_score;
   logic       check_valid, score_ok, error;
   logic [2:0] err_code;
   logic [7:0] rounds, pwins, dwins, ties;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hex_round_monitor #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
      .CLOCK_50(clk), .resetb(resetb),
      .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
      .LEDR(ledr),
      .player_score(player_score), .dealer_score(dealer_score),
      .check_valid(check_valid), .score_ok(score_ok),
      .error(error), .err_code(err_code),
      .rounds(rounds), .pwins(pwins), .dwins(dwins), .ties(ties)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic apply(input logic [6:0] h0, h1, h2, h3, h4, h5, input logic [9:0] led);
      @(negedge clk);
      hex0 = h0; hex1 = h1; hex2 = h2; hex3 = h3; hex4 = h4; hex5 = h5; ledr = led;
   endtask

   task automatic wait_cv(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!check_valid && n < 40);
      check(tag, check_valid, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetb = 1'b0;
      hex0 = S_BL; hex1 = S_BL; hex2 = S_BL; hex3 = S_BL; hex4 = S_BL; hex5 = S_BL; ledr = '0;
      @(negedge clk);
      @(negedge clk);
      resetb = 1'b1;
      wait_cv("cv_blank_after_reset");
   endtask

   initial begin
      int cnt;
      // Reset values while held in reset
      #2;
      check("rst_error", error, 0);
      check("rst_rounds", rounds, 0);
      check("rst_cv", check_valid, 0);
      @(negedge clk);
      @(negedge clk);
      resetb = 1'b1;
      wait_cv("cv_initial_blank");
      check("init_error", error, 0);
      cnt = 0;
      repeat (20) begin @(posedge clk); #1; if (check_valid) cnt++; end
      check("no_more_cv", cnt, 0);

      // Player 3,5 vs dealer 3,7: player 8, dealer 0, player wins
      apply(S_3, S_BL, S_BL, S_3, S_BL, S_BL, 10'h033);
      wait_cv("cv_r1_s1");
      check("r1_s1_pscore", player_score, 3);
      check("r1_s1_score_ok", score_ok, 1);
      apply(S_3, S_5, S_BL, S_3, S_7, S_BL, 10'h108);
      wait_cv("cv_r1_s2");
      check("r1_pscore", player_score, 8);
      check("r1_dscore", dealer_score, 0);
      check("r1_score_ok", score_ok, 1);
      check("r1_pwins", pwins, 1);
      check("r1_rounds", rounds, 1);
      check("r1_error", error, 0);

      // Player 2,2 vs dealer K,9: player 4, dealer 9, dealer wins
      apply(S_BL, S_BL, S_BL, S_BL, S_BL, S_BL, 10'h000);
      wait_cv("cv_r2_blank");
      apply(S_2, S_BL, S_BL, S_K, S_BL, S_BL, 10'h002);
      wait_cv("cv_r2_s1");
      apply(S_2, S_2, S_BL, S_K, S_9, S_BL, 10'h294);
      wait_cv("cv_r2_s2");
      check("r2_pscore", player_score, 4);
      check("r2_dscore", dealer_score, 9);
      check("r2_dwins", dwins, 1);
      check("r2_rounds", rounds, 2);
      check("r2_ties", ties, 0);
      check("r2_error", error, 0);

      // Same hands, LEDR claims a player win: winner mismatch
      apply(S_BL, S_BL, S_BL, S_BL, S_BL, S_BL, 10'h000);
      wait_cv("cv_r3_blank");
      apply(S_2, S_BL, S_BL, S_K, S_BL, S_BL, 10'h002);
      wait_cv("cv_r3_s1");
      apply(S_2, S_2, S_BL, S_K, S_9, S_BL, 10'h194);
      wait_cv("cv_r3_s2");
      check("r3_error", error, 1);
      check("r3_err_code", err_code, 5);
      check("r3_rounds", rounds, 3);
      check("r3_score_ok", score_ok, 1);

      // Asynchronous reset mid-round, away from any clock edge
      apply(S_BL, S_BL, S_BL, S_BL, S_BL, S_BL, 10'h000);
      wait_cv("cv_r4_blank");
      apply(S_2, S_BL, S_BL, S_K, S_BL, S_BL, 10'h002);
      wait_cv("cv_r4_s1");
      #3;
      resetb = 1'b0;
      #1;
      check("async_rounds", rounds, 0);
      check("async_dwins", dwins, 0);
      check("async_error", error, 0);
      check("async_err_code", err_code, 0);
      check("async_pscore", player_score, 0);
      check("async_cv", check_valid, 0);
      do_reset();

      // HEX1 dealt while HEX3 still blank
      apply(S_3, S_5, S_BL, S_BL, S_BL, S_BL, 10'h008);
      wait_cv("cv_order");
      check("order_error", error, 1);
      check("order_err_code", err_code, 3);
      apply(S_5, S_5, S_BL, S_BL, S_BL, S_BL, 10'h000);
      wait_cv("cv_order2");
      check("first_code_kept", err_code, 3);

      // Undecodable segment pattern
      do_reset();
      apply(S_BAD, S_BL, S_BL, S_BL, S_BL, S_BL, 10'h000);
      wait_cv("cv_bad");
      check("bad_error", error, 1);
      check("bad_err_code", err_code, 1);

      // HEX0 toggling every 2 clocks never settles
      do_reset();
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         hex0 = (k % 2 == 0) ? S_3 : S_BL;
         repeat (2) begin @(posedge clk); #1; if (check_valid) cnt++; end
      end
      check("toggle_no_cv", cnt, 0);
      apply(S_3, S_BL, S_BL, S_BL, S_BL, S_BL, 10'h003);
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (!check_valid && cnt < 40);
      check("hold_cv", check_valid, 1);
      check("hold_latency_ok", (cnt >= 4 && cnt <= 9), 1);
      check("hold_pscore", player_score, 3);
      check("hold_error", error, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hex_round_monitor.md
Name: hex_round_monitor

Overview:
- Observer-side counterpart of the baccarat top level. It reads the six seven-segment card displays and the LEDR score/win outputs, then decodes them back into card values.
- It recomputes both hands' scores and the expected winner, and checks them against LEDR.
- It tracks round progress and keeps win/loss/tie tallies.
- It sits beside the game on the board (or in a bench) as a self-checking monitor. It never drives the game.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronized samples needed before a snapshot is taken (min 2).
- CNT_W, 8: width of the saturating round/win counters.

Ports:
- CLOCK_50  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- HEX0..HEX5  in  7 each  active-low segments: HEX0-2 are player cards 1-3, HEX3-5 are dealer cards 1-3
- LEDR  in  10  [3:0] player score, [7:4] dealer score, [8] player wins, [9] dealer wins
- player_score  out  4  recomputed player score
- dealer_score  out  4  recomputed dealer score
- check_valid  out  1  one-cycle pulse when a snapshot has been evaluated
- score_ok  out  1  valid with check_valid: both recomputed scores equal LEDR
- error  out  1  sticky error flag
- err_code  out  3  first error latched
- rounds  out  CNT_W  completed rounds
- pwins  out  CNT_W  player-win rounds
- dwins  out  CNT_W  dealer-win rounds
- ties  out  CNT_W  tied rounds

Behaviour:
- Reset (async, resetb=0): all outputs 0; FSM in WAIT_BLANK; synchronizer, stability counter and snapshot cleared (snapshot = all blank, LEDR=0).
- Input path:
  - The 52 input bits pass through a 2-flop synchronizer (the game runs on KEY[0], which is asynchronous to CLOCK_50).
  - The stability counter resets on any bit change and otherwise increments, saturating at STABLE_CYCLES.
  - When it reaches STABLE_CYCLES and the value differs from the stored snapshot, that value is captured once.
  - check_valid pulses on the following cycle, with all outputs updated that cycle.
  - Worst-case latency from a pin change to check_valid: 2 + STABLE_CYCLES + 1 clocks.
- Decode per digit:
  - blank 1111111 → 0
  - A 0001000 → 1
  - 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000
  - 10 1000000, J 1100001, Q 0011000, K 0001001 → 10..13
  - Any other pattern is invalid (err 1).
- Score: sum of the card values with 10..13 and blank counted as 0, mod 10; a 5-bit intermediate is sufficient.
- FSM, evaluated per snapshot:
  - WAIT_BLANK: all six digits blank and LEDR[9:8]=00 → IDLE; otherwise stay (no checks besides decode).
  - IDLE: any digit non-blank → IN_ROUND.
  - IN_ROUND:
    - Slot order: HEX1 non-blank requires HEX0 and HEX3 non-blank; HEX4 requires HEX1; HEX2 requires HEX4; HEX5 requires HEX4. Violation → err 3.
    - A slot that was non-blank must keep its value; otherwise err 4.
    - Scores ≠ LEDR → err 2 (score_ok=0).
    - LEDR[9:8] ≠ 00 → check the winner: player>dealer needs 01, dealer>player needs 10, equal needs 11; mismatch → err 5. Then increment rounds plus the matching tally and go to DONE.
  - DONE: all blank with LEDR[9:8]=00 (game reset) → IDLE; any other change is ignored.
- Errors:
  - error is set on the first error; err_code holds the first code, and later errors do not overwrite it.
  - The FSM keeps running after an error; clear only by reset.
  - If an invalid pattern and another error occur in the same snapshot, the code is 1.
- Counters saturate at all-ones.
- Reset mid-round clears everything, including the tallies.
- Snapshot equal to the previous snapshot: no capture, no check_valid.

Test Plan:
- Reset, then all blank with LEDR=0 → state IDLE, error=0, no further check_valid.
- Player 3,5 (HEX0=0110000, HEX1=0010010); dealer 3,7 (HEX3=0110000, HEX4=1111000); LEDR=0x108 → player_score=8, dealer_score=0, score_ok=1, pwins=1, rounds=1, error=0.
- Dealer K,9 and player 2,2, with LEDR[9:8]=10, dealer score 9, player score 4 → dwins=1.
- Same hands but LEDR[8]=1 only → error=1, err_code=5.
- HEX1 non-blank while HEX3 is blank → err_code=3.
- HEX0 set to 1010101 → err_code=1.
- HEX0 toggling every 2 clocks with STABLE_CYCLES=4 → no check_valid until the value holds for 4 clocks.
- resetb pulsed low mid-round → outputs 0 immediately, without waiting for a clock edge.
